// File: rtl/pulse_sync_pkg.sv
// Shared definitions for the receive side of the toggle pulse-synchronizer link.
//   MODE_PULSE / MODE_HS : values of the pMODE parameter
//   MAX_STAGES           : deepest supported synchronizer chain
//   hs_state_e           : per-channel handshake state
package pulse_sync_pkg;

    localparam int MODE_PULSE = 0;
    localparam int MODE_HS    = 1;
    localparam int MAX_STAGES = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } hs_state_e;

endpackage

// File: rtl/pulse_sync_rx_ch.sv
// One receive channel: synchronizes the sender's request toggle, detects its
// transitions and turns each into either a one-cycle pulse (MODE_PULSE) or a
// valid/ready event (MODE_HS), and returns an acknowledge toggle.
// Ports:
//   clk, rst  : receiving clock, synchronous active-high reset
//   req_tgl   : asynchronous request toggle from the sender
//   armed     : high once the post-reset arming window has elapsed
//   evt_rdy   : consumer ready (handshake mode only)
//   ovf_clr   : clears the sticky violation flag
//   evt_vld   : event valid
//   ack_tgl   : acknowledge toggle back to the sender
//   ovf       : sticky protocol-violation flag
//   drop      : combinational, high in the cycle an event is being dropped
module pulse_sync_rx_ch
    import pulse_sync_pkg::*;
#(
    parameter int pSTAGES = 2,
    parameter int pMODE   = MODE_HS
) (
    input  logic clk,
    input  logic rst,
    input  logic req_tgl,
    input  logic armed,
    input  logic evt_rdy,
    input  logic ovf_clr,
    output logic evt_vld,
    output logic ack_tgl,
    output logic ovf,
    output logic drop
);

    (* ASYNC_REG = "TRUE", keep = "true" *) logic [pSTAGES-1:0] sync_r;
    logic      lvl_r;
    hs_state_e state_r;
    logic      edge_s;
    logic      fire_s;

    // Transition detect on the synchronized level; suppressed while arming
    always_comb begin
        edge_s = sync_r[pSTAGES-1] ^ lvl_r;
        fire_s = edge_s & armed;
        if ((pMODE == MODE_HS) && (state_r == PEND)) begin
            drop = fire_s & ~evt_rdy;
        end else begin
            drop = 1'b0;
        end
    end

    // Sync chain, edge register and per-mode event/ack/violation state
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r  <= '0;
            lvl_r   <= 1'b0;
            state_r <= IDLE;
            evt_vld <= 1'b0;
            ack_tgl <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            sync_r <= {sync_r[pSTAGES-2:0], req_tgl};
            lvl_r  <= sync_r[pSTAGES-1];
            if (pMODE == MODE_PULSE) begin
                state_r <= IDLE;
                evt_vld <= fire_s;
                ack_tgl <= lvl_r;
                ovf     <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (fire_s) begin
                            state_r <= PEND;
                            evt_vld <= 1'b1;
                        end
                    end
                    PEND: begin
                        // Accept; a coincident new edge becomes the next pending event
                        if (evt_rdy) begin
                            ack_tgl <= ~ack_tgl;
                            if (!fire_s) begin
                                state_r <= IDLE;
                                evt_vld <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        evt_vld <= 1'b0;
                    end
                endcase
                // A new violation wins over a clear in the same cycle
                ovf <= (ovf & ~ovf_clr) | drop;
            end
        end
    end

endmodule

// File: rtl/pulse_sync_rx_hs.sv
// Multi-channel receive side of a two-phase pulse-synchronizer link.
// Holds the post-reset arming counter and the saturating drop counter, and
// instantiates one pulse_sync_rx_ch per channel.
// Ports:
//   clk, rst : receiving clock, synchronous active-high reset
//   req_tgl  : [pCH] asynchronous request toggles
//   ack_tgl  : [pCH] acknowledge toggles to the sender
//   evt_vld  : [pCH] event valid
//   evt_rdy  : [pCH] consumer ready (handshake mode only)
//   ovf      : [pCH] sticky protocol-violation flags
//   ovf_clr  : [pCH] violation flag clears
//   drop_cnt : [pCNT_W] saturating count of dropped events, all channels
//   armed    : high once the arming window has elapsed
module pulse_sync_rx_hs
    import pulse_sync_pkg::*;
#(
    parameter int pCH     = 4,
    parameter int pSTAGES = 2,
    parameter int pMODE   = MODE_HS,
    parameter int pCNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [pCH-1:0]    req_tgl,
    output logic [pCH-1:0]    ack_tgl,
    output logic [pCH-1:0]    evt_vld,
    input  logic [pCH-1:0]    evt_rdy,
    output logic [pCH-1:0]    ovf,
    input  logic [pCH-1:0]    ovf_clr,
    output logic [pCNT_W-1:0] drop_cnt,
    output logic              armed
);

    localparam int ARM_W = $clog2(MAX_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(pSTAGES);
    localparam int POP_W = $clog2(pCH + 1);
    localparam int SUM_W = pCNT_W + POP_W;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({pCNT_W{1'b1}});

    logic [ARM_W-1:0]  arm_cnt_r;
    logic [pCH-1:0]    drop_s;
    logic [POP_W-1:0]  pop_s;
    logic [SUM_W-1:0]  sum_s;
    logic [pCNT_W-1:0] sat_s;

    // Number of channels dropping this cycle, added to the count with saturation
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < pCH; i++) begin
            pop_s = pop_s + POP_W'(drop_s[i]);
        end
        sum_s = SUM_W'(drop_cnt) + SUM_W'(pop_s);
        if (sum_s > CNT_MAX) begin
            sat_s = CNT_MAX[pCNT_W-1:0];
        end else begin
            sat_s = sum_s[pCNT_W-1:0];
        end
    end

    // Arming window of pSTAGES+1 cycles lets the sync chain flush any level
    // present at reset into the edge register without producing an event
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt_r <= '0;
            armed     <= 1'b0;
        end else if (!armed) begin
            if (arm_cnt_r == ARM_LAST) begin
                armed <= 1'b1;
            end else begin
                arm_cnt_r <= arm_cnt_r + ARM_W'(1);
            end
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    // Saturating drop counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (pMODE == MODE_PULSE) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= sat_s;
        end
    end

    for (genvar g = 0; g < pCH; g++) begin : g_ch
        pulse_sync_rx_ch #(
            .pSTAGES (pSTAGES),
            .pMODE   (pMODE)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .req_tgl (req_tgl[g]),
            .armed   (armed),
            .evt_rdy (evt_rdy[g]),
            .ovf_clr (ovf_clr[g]),
            .evt_vld (evt_vld[g]),
            .ack_tgl (ack_tgl[g]),
            .ovf     (ovf[g]),
            .drop    (drop_s[g])
        );
    end

endmodule

// File: doc/pulse_sync_rx_hs.md
Name: pulse_sync_rx_hs

Overview:
- Multi-channel receive side of a two-phase (toggle) pulse-synchronizer link. Runs entirely in the receiving clock domain.
- Each channel synchronizes an asynchronous request-toggle level through a pSTAGES flop chain and edge-detects it into a pulse or a valid/ready event. It also returns an acknowledge toggle that the sender synchronizes on its own side.
- Adds per-channel handshake mode, a post-reset arming window, protocol-violation detection and a drop counter.

Parameters:
- pCH, 4, number of independent channels (1..32)
- pSTAGES, 2, synchronizer flop depth (2..4)
- pMODE, 1, 0 = fire-and-forget single-cycle pulse; 1 = valid/ready handshake
- pCNT_W, 8, width of saturating drop counter

Ports:
- clk  in  1  receiving-domain clock
- rst  in  1  synchronous, active-high reset
- req_tgl  in  pCH  async request toggles from sender domain; each transition is one event
- ack_tgl  out  pCH  acknowledge toggles to sender domain (sender-side sync required)
- evt_vld  out  pCH  event valid (mode 0: 1-cycle pulse; mode 1: held until accepted)
- evt_rdy  in  pCH  consumer ready (ignored in mode 0)
- ovf  out  pCH  sticky per-channel protocol-violation flag
- ovf_clr  in  pCH  clears ovf bits; set has priority over clear in the same cycle
- drop_cnt  out  pCNT_W  saturating total count of dropped events, all channels
- armed  out  1  high once the arming window has elapsed

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset (rst=1 at an edge) clears the sync chains, edge register, evt_vld, ack_tgl, ovf, drop_cnt, armed and the arm counter. All outputs are 0.
- Arming window:
  - After rst deasserts, a counter runs pSTAGES+1 cycles. During the window the edge register tracks the sync output and no events are generated.
  - armed rises on the edge ending the window.
  - Any sender level present at reset never produces a spurious event.
- Latency: a req_tgl transition meeting setup before edge E0 lands in sync[0] at E0 and in sync[last] at E(pSTAGES-1). evt_vld rises at E(pSTAGES). Example: pSTAGES=2 gives evt_vld high after E2.
- Edge detect: edge = sync[last] XOR lvl_q; lvl_q <= sync[last] every cycle.
- Mode 0:
  - evt_vld is high exactly one cycle per edge.
  - ack_tgl <= lvl_q, i.e. it follows the detected level one cycle after the edge register.
  - ovf and drop_cnt are unused and held at 0.
- Mode 1, per-channel FSM:
  - IDLE: on edge, go to PEND and assert evt_vld.
  - PEND: on evt_vld & evt_rdy, flip ack_tgl at the same edge. Go to IDLE and drop evt_vld, unless a new edge occurs in the same cycle; then stay in PEND with evt_vld held high (new event, no ovf).
  - PEND with edge and no evt_rdy is a sender protocol violation. The new event is dropped, ovf[ch] sets, drop_cnt increments, and the pending event is unaffected.
- drop_cnt:
  - Increments by the number of channels dropping in a cycle (popcount).
  - Saturates at 2^pCNT_W-1; no wrap.
  - Cleared only by reset.
- Channels are fully independent; simultaneous events on all channels are legal.
- rst mid-handshake: the pending event is lost, ack_tgl returns to 0 and the arming window restarts. Sender and receiver resets must be applied together at system level.
- Sync flops carry the synthesis/CDC keep attribute. There is no logic between sync stages.

Decomposition:
- Shared package pulse_sync_pkg:
  - MODE_PULSE=0, MODE_HS=1
  - FSM state typedef {IDLE, PEND}
  - MAX_STAGES=4
- One natural sub-module: pulse_sync_rx_ch.
  - Contains the per-channel sync chain, edge register, FSM, ack toggle and ovf.
  - Instantiated pCH times via generate.
- The top level holds the arm counter, drop popcount and the saturating counter.

Test Plan:
1. Reset with req_tgl=4'b1111 held, then deassert rst -> no evt_vld during 3 cycles; armed=1 at cycle 3; evt_vld stays 0 afterwards.
2. pMODE=1, pSTAGES=2: toggle req_tgl[0] before E0 with evt_rdy=1 -> evt_vld[0] high after E2 for 1 cycle; ack_tgl[0] flips at E3.
3. pMODE=1, evt_rdy[1]=0: two toggles on ch1 10 cycles apart -> evt_vld[1] held; ovf[1]=1; drop_cnt=1; then evt_rdy=1 -> single accept and a single ack flip.
4. pMODE=1: new edge on ch2 in the same cycle as accept -> evt_vld[2] stays high; ovf[2]=0; ack flips once; second accept flips ack again.
5. pMODE=1, pCNT_W=2: 5 violations across ch0/ch3, including 2 in one cycle -> drop_cnt sequence 2,3,3 (saturates at 3); ovf_clr while a set is pending leaves ovf=1.
6. pMODE=0: 8 toggles spaced 4 cycles on all channels -> 8 single-cycle evt_vld pulses per channel, each at latency pSTAGES+1; ack_tgl equals req_tgl after settling.
